// File: rtl/quad_sample_packer_pkg.sv
// quad_sample_packer_pkg
//   Shared types and constants for the quad sample packer and its bench.
//   W         : sample width in bits (unsigned samples)
//   PAD       : filler value for unused slots of a short group (all ones)
//   count_t   : number of real samples in a group, 1..4
//   slot_idx_t: fill position 0..3 inside the group being assembled
//   packer_dbg_t : observable fill-stage state (slot index, pending flag)
package quad_sample_packer_pkg;

   localparam int W       = 8;
   localparam int N_SLOTS = 4;

   // All ones is the identity of an unsigned minimum, so padded slots
   // never change the downstream result.
   localparam logic [W-1:0] PAD = '1;

   typedef logic [2:0] count_t;
   typedef logic [1:0] slot_idx_t;

   typedef struct packed {
      slot_idx_t idx;
      logic      pend;
   } packer_dbg_t;

   // Number of real samples in a group that closes while writing slot idx.
   function automatic count_t count_at_close(slot_idx_t idx);
      return count_t'(idx) + 3'd1;
   endfunction

endpackage

// File: rtl/quad_sample_packer_if.sv
// quad_sample_packer_if
//   Bundles the sample input stream and the grouped output stream.
//   Handshake rule (both streams): a transfer happens on a rising clk edge
//   where valid && ready are both high; the source holds data stable while
//   valid is high and ready is low; ready may depend on state only.
//   Input stream : in_valid, in_ready, in_data, in_last
//   Output stream: out_valid, out_ready, out_a..out_d (slots 0..3 in
//                  arrival order), out_count (1..4 real samples)
//   dbg_state    : fill-stage state for observation only
//   Modports: master = environment (sample source / group sink),
//             slave  = the packer.
interface quad_sample_packer_if;
   import quad_sample_packer_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_last;

   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_a;
   logic [W-1:0]  out_b;
   logic [W-1:0]  out_c;
   logic [W-1:0]  out_d;
   count_t        out_count;

   packer_dbg_t   dbg_state;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_c, out_d, out_count,
      input  dbg_state
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_a, out_b, out_c, out_d, out_count,
      output dbg_state
   );

endinterface

// File: rtl/quad_sample_packer.sv
// quad_sample_packer
//   Packs unsigned samples (one per cycle) into groups of four and presents
//   each group as four parallel operands. A group closes on its fourth
//   sample or on any sample flagged in_last; missing slots are filled with
//   PAD. Double-buffered: a fill stage (f0..f3 + pend) and an output
//   register, so one group can wait while the previous one is stalled.
//   Ports:
//     clk   : clock, all logic on the rising edge
//     reset : synchronous, active-high
//     bus   : quad_sample_packer_if.slave (input stream, output stream,
//             debug state)
module quad_sample_packer
   import quad_sample_packer_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   quad_sample_packer_if.slave   bus
);

   // Fill stage
   slot_idx_t     idx_q, idx_d;
   logic          pend_q, pend_d;
   count_t        pend_cnt_q, pend_cnt_d;
   logic [W-1:0]  f_q [N_SLOTS];
   logic [W-1:0]  f_d [N_SLOTS];

   // Output register
   logic          out_valid_q, out_valid_d;
   count_t        out_count_q, out_count_d;
   logic [W-1:0]  out_q [N_SLOTS];
   logic [W-1:0]  out_d [N_SLOTS];

   // Handshake terms
   logic          in_ready;
   logic          in_fire;
   logic          out_free;
   logic          closing;

   // The group as it would look if it closed this cycle
   logic [W-1:0]  grp [N_SLOTS];
   count_t        grp_cnt;

   assign in_ready = !pend_q && !reset;
   assign in_fire  = bus.in_valid && in_ready;
   assign out_free = !out_valid_q || bus.out_ready;
   assign closing  = in_fire && ((idx_q == 2'd3) || bus.in_last);

   // Slots below idx come from the fill registers, slot idx is the closing
   // sample itself (bypassing f*), slots above idx are padding.
   always_comb begin
      for (int i = 0; i < N_SLOTS; i++) begin
         grp[i] = PAD;
         if (slot_idx_t'(i) < idx_q) begin
            grp[i] = f_q[i];
         end else if (slot_idx_t'(i) == idx_q) begin
            grp[i] = bus.in_data;
         end
      end
      grp_cnt = count_at_close(idx_q);
   end

   always_comb begin
      idx_d       = idx_q;
      pend_d      = pend_q;
      pend_cnt_d  = pend_cnt_q;
      f_d         = f_q;
      out_valid_d = out_valid_q;
      out_count_d = out_count_q;
      out_d       = out_q;

      // Current group leaves; a load below may refill the register this edge.
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (pend_q) begin
         // in_ready is low while pending, so no sample can arrive here.
         if (out_free) begin
            out_d       = f_q;
            out_count_d = pend_cnt_q;
            out_valid_d = 1'b1;
            pend_d      = 1'b0;
         end
      end else if (in_fire) begin
         if (closing) begin
            idx_d = 2'd0;
            if (out_free) begin
               out_d       = grp;
               out_count_d = grp_cnt;
               out_valid_d = 1'b1;
            end else begin
               f_d        = grp;
               pend_cnt_d = grp_cnt;
               pend_d     = 1'b1;
            end
         end else begin
            f_d[idx_q] = bus.in_data;
            idx_d      = idx_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q       <= '0;
         pend_q      <= 1'b0;
         pend_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
         for (int i = 0; i < N_SLOTS; i++) begin
            f_q[i]   <= '0;
            out_q[i] <= '0;
         end
      end else begin
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         pend_cnt_q  <= pend_cnt_d;
         out_valid_q <= out_valid_d;
         out_count_q <= out_count_d;
         f_q         <= f_d;
         out_q       <= out_d;
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_a          = out_q[0];
   assign bus.out_b          = out_q[1];
   assign bus.out_c          = out_q[2];
   assign bus.out_d          = out_q[3];
   assign bus.out_count      = out_count_q;
   assign bus.dbg_state.idx  = idx_q;
   assign bus.dbg_state.pend = pend_q;

endmodule

// File: tb/tb_quad_sample_packer.sv
// tb_quad_sample_packer
//   Self-checking bench for quad_sample_packer: directed vector table,
//   hand-written stall/reset sequences, and a random handshake run, all
//   backed by a scoreboard that models grouping and padding.
module tb_quad_sample_packer;
   import quad_sample_packer_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   quad_sample_packer_if bus();

   quad_sample_packer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- bookkeeping ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] min4(input logic [W-1:0] a, b, c, d);
      logic [W-1:0] m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      if (d < m) m = d;
      return m;
   endfunction

   // ---------------- scoreboard ----------------
   typedef logic [3+4*W-1:0] grp_t;   // {count, a, b, c, d}
   grp_t exp_q[$];
   logic [W-1:0] part [4];
   int pidx   = 0;
   int n_out  = 0;
   int n_push = 0;

   always @(negedge clk) begin
      grp_t e;
      logic [W-1:0] s [4];
      if (reset) begin
         exp_q.delete();
         pidx = 0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            chk("sb_group_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_group", {bus.out_count, bus.out_a, bus.out_b, bus.out_c, bus.out_d}, e);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            part[pidx] = bus.in_data;
            if (pidx == 3 || bus.in_last) begin
               for (int k = 0; k < 4; k++) s[k] = (k <= pidx) ? part[k] : {W{1'b1}};
               exp_q.push_back({3'(pidx + 1), s[0], s[1], s[2], s[3]});
               n_push++;
               pidx = 0;
            end else begin
               pidx++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic l);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      @(negedge clk);
      while (!bus.in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("send_accept", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk(nm, exp_q.size(), 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int            n;
      logic [W-1:0]  s [4];
      logic          last;
      logic [W-1:0]  e [4];
      int            cnt;
      logic [W-1:0]  emin;
   } vec_t;

   function automatic vec_t mk(input int n,
                               input logic [W-1:0] s0, s1, s2, s3,
                               input logic last,
                               input logic [W-1:0] e0, e1, e2, e3,
                               input int cnt, input logic [W-1:0] emin);
      vec_t v;
      v.n = n;
      v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
      v.last = last;
      v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
      v.cnt = cnt;
      v.emin = emin;
      return v;
   endfunction

   vec_t vt [5];
   logic rand_done;

   initial begin
      int c0, o0, p0;

      vt[0] = mk(4,   9,   3,   7, 5, 1'b0,   9,   3,   7,   5, 4,   3);
      vt[1] = mk(2,  20,  10,   0, 0, 1'b1,  20,  10, 255, 255, 2,  10);
      vt[2] = mk(1,   0,   0,   0, 0, 1'b1,   0, 255, 255, 255, 1,   0);
      vt[3] = mk(4,   1,   2,   3, 4, 1'b1,   1,   2,   3,   4, 4,   1);
      vt[4] = mk(3, 200, 255, 100, 0, 1'b1, 200, 255, 100, 255, 3, 100);

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready_low", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_count", bus.out_count, 0);
      chk("rst_out_data", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, 0);
      sync();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 1);
      sync();

      // Table: back-to-back samples with output always ready
      bus.out_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         c0 = cyc;
         for (int j = 0; j < vt[v].n; j++) send(vt[v].s[j], vt[v].last && (j == vt[v].n - 1));
         chk("vec_throughput", cyc - c0, vt[v].n);
         @(negedge clk);
         chk("vec_out_valid", bus.out_valid, 1);
         chk("vec_out_a", bus.out_a, vt[v].e[0]);
         chk("vec_out_b", bus.out_b, vt[v].e[1]);
         chk("vec_out_c", bus.out_c, vt[v].e[2]);
         chk("vec_out_d", bus.out_d, vt[v].e[3]);
         chk("vec_out_count", bus.out_count, vt[v].cnt);
         chk("vec_min", min4(bus.out_a, bus.out_b, bus.out_c, bus.out_d), vt[v].emin);
         @(negedge clk);
         chk("vec_valid_one_cycle", bus.out_valid, 0);
         sync();
      end

      // Stall: 1..8 fill output + pending, 9..12 resume after release
      o0 = n_out;
      bus.out_ready = 1'b0;
      for (int v = 1; v <= 8; v++) send(W'(v), 1'b0);
      @(negedge clk);
      chk("stall_in_ready_low", bus.in_ready, 0);
      chk("stall_pend", bus.dbg_state.pend, 1);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_out_group", {bus.out_count, bus.out_a, bus.out_b, bus.out_c, bus.out_d},
          {3'd4, 8'd1, 8'd2, 8'd3, 8'd4});
      repeat (3) sync();
      @(negedge clk);
      chk("stall_hold_in_ready", bus.in_ready, 0);
      chk("stall_hold_out_a", bus.out_a, 1);
      sync();
      fork
         begin
            for (int v = 9; v <= 12; v++) send(W'(v), 1'b0);
         end
         begin
            repeat (2) sync();
            bus.out_ready = 1'b1;
         end
      join
      drain("stall_drain");
      chk("stall_group_total", n_out - o0, 3);

      // Reset in the middle of a group
      sync();
      bus.out_ready = 1'b1;
      send(7, 1'b0);
      send(8, 1'b0);
      reset = 1'b1;
      sync();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_out_valid", bus.out_valid, 0);
      chk("rst_mid_in_ready", bus.in_ready, 1);
      chk("rst_mid_idx", bus.dbg_state.idx, 0);
      sync();
      for (int j = 0; j < 4; j++) send(4, 1'b0);
      @(negedge clk);
      chk("rst_mid_next_group", {bus.out_valid, bus.out_count, bus.out_a, bus.out_b, bus.out_c, bus.out_d},
          {1'b1, 3'd4, 8'd4, 8'd4, 8'd4, 8'd4});
      sync();

      // Reset while a group is pending
      bus.out_ready = 1'b0;
      for (int v = 1; v <= 8; v++) send(W'(v), 1'b0);
      reset = 1'b1;
      sync();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("rst_pend_out_valid", bus.out_valid, 0);
      chk("rst_pend_in_ready", bus.in_ready, 1);
      chk("rst_pend_flag", bus.dbg_state.pend, 0);
      sync();
      send(6, 1'b1);
      @(negedge clk);
      chk("rst_pend_no_stale", {bus.out_count, bus.out_a, bus.out_b, bus.out_c, bus.out_d},
          {3'd1, 8'd6, 8'd255, 8'd255, 8'd255});
      sync();
      for (int j = 0; j < 4; j++) send(4, 1'b0);
      @(negedge clk);
      chk("rst_pend_next_group", {bus.out_count, bus.out_a, bus.out_b, bus.out_c, bus.out_d},
          {3'd4, 8'd4, 8'd4, 8'd4, 8'd4});
      sync();
      drain("rst_drain");

      // Random valid/ready traffic
      o0 = n_out;
      p0 = n_push;
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               repeat ($urandom_range(0, 2)) sync();
               send(W'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
            end
            send(W'($urandom_range(0, 255)), 1'b1);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               sync();
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain("rand_drain");
      chk("rand_group_total", n_out - o0, n_push - p0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
